// File: rtl/csr_pkg.sv
// Shared types for the machine-mode CSR file and trap controller:
// CSR addresses, write-op encodings, mstatus bit positions, trap FSM states.
package csr_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned IRQ_BASE     = 16;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    typedef enum logic [11:0] {
        CSR_MSTATUS = 12'h300,
        CSR_MIE     = 12'h304,
        CSR_MTVEC   = 12'h305,
        CSR_MEPC    = 12'h341,
        CSR_MCAUSE  = 12'h342,
        CSR_MIP     = 12'h344,
        CSR_MCYCLE  = 12'hB00,
        CSR_MCYCLEH = 12'hB80
    } type_csr_addr;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } type_csr_op;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TRAP = 1'b1
    } type_trap_state;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] evec;
    } type_redirect;

    // Read-modify-write result for csrrw/csrrs/csrrc.
    function automatic logic [XLEN-1:0] csr_alu(input type_csr_op      op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] res;
        res = old_val;
        case (op)
            OP_WRITE: res = wdata;
            OP_SET:   res = old_val | wdata;
            OP_CLEAR: res = old_val & ~wdata;
            default:  res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_irq_unit_if.sv
// CSR access and PC-redirect bus between decode/execute and the CSR unit.
interface csr_irq_unit_if;

    logic        csr_rd_en;
    logic        csr_wr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_pc;
    logic        csr_is_mret;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] csr_evec;

    modport master (
        output csr_rd_en, csr_wr_en, csr_op, csr_addr, csr_wdata, csr_pc, csr_is_mret,
        input  csr_rdata, epc_taken, csr_evec
    );

    modport slave (
        input  csr_rd_en, csr_wr_en, csr_op, csr_addr, csr_wdata, csr_pc, csr_is_mret,
        output csr_rdata, epc_taken, csr_evec
    );

endinterface

// File: rtl/csr_irq_arb.sv
// Interrupt edge detection, pending (mip) register and fixed-priority selection.
module csr_irq_arb
    import csr_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] mask_i,
    input  logic               pend_wr_en_i,
    input  logic [NUM_IRQ-1:0] pend_wr_val_i,
    input  logic               clr_en_i,
    input  logic [IDX_W-1:0]   clr_idx_i,
    output logic [NUM_IRQ-1:0] pend_o,
    output logic               valid_c_o,
    output logic [IDX_W-1:0]   idx_c_o
);

    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] rise_c;
    logic [NUM_IRQ-1:0] elig_c;

    assign rise_c = irq_i & ~irq_prev_q;
    assign elig_c = pend_q & mask_i;
    assign pend_o = pend_q;

    // Software write, then trap-entry clear, then new edges (edges always win).
    always_comb begin
        pend_d = pend_q;
        if (pend_wr_en_i) begin
            pend_d = pend_wr_val_i;
        end
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (clr_en_i && (clr_idx_i == IDX_W'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
        pend_d = pend_d | rise_c;
    end

    // Scan from the top so the lowest eligible index is left selected.
    always_comb begin
        valid_c_o = 1'b0;
        idx_c_o   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig_c[i]) begin
                valid_c_o = 1'b1;
                idx_c_o   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            irq_prev_q <= irq_i;
            pend_q     <= pend_d;
        end
    end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with prioritised edge interrupts, mret and a registered
// trap/return redirect to fetch.
module csr_irq_unit
    import csr_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 4,
    parameter logic [31:0] RESET_MTVEC = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    csr_irq_unit_if.slave      bus
);

    type_trap_state     state_q, state_d;
    type_redirect       redir_q, redir_d;
    logic               mst_mie_q, mst_mie_d;
    logic               mst_mpie_q, mst_mpie_d;
    logic [NUM_IRQ-1:0] mie_en_q, mie_en_d;
    logic [XLEN-1:0]    mtvec_q, mtvec_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [XLEN-1:0]    mcause_q, mcause_d;
    logic [63:0]        mcycle_q, mcycle_d;

    type_csr_addr       addr_c;
    logic [NUM_IRQ-1:0] mip_c;
    logic               irq_valid_c;
    logic [IDX_W-1:0]   irq_idx_c;
    logic [XLEN-1:0]    mstatus_c, mepc_rd_c, cur_c, new_c, vec_c;
    logic [XLEN-2:0]    cause_c;
    logic               hit_c, wr_c, mip_wr_c, take_c, mret_c;

    csr_irq_arb #(
        .NUM_IRQ(NUM_IRQ)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq),
        .mask_i       (mie_en_q),
        .pend_wr_en_i (mip_wr_c),
        .pend_wr_val_i(new_c[IRQ_BASE +: NUM_IRQ]),
        .clr_en_i     (take_c),
        .clr_idx_i    (irq_idx_c),
        .pend_o       (mip_c),
        .valid_c_o    (irq_valid_c),
        .idx_c_o      (irq_idx_c)
    );

    assign addr_c    = type_csr_addr'(bus.csr_addr);
    assign mepc_rd_c = mepc_q & ~XLEN'(32'h3);

    always_comb begin
        mstatus_c               = '0;
        mstatus_c[MSTATUS_MIE]  = mst_mie_q;
        mstatus_c[MSTATUS_MPIE] = mst_mpie_q;
    end

    // Current CSR value; also the old operand of the write-op ALU.
    always_comb begin
        cur_c = '0;
        hit_c = 1'b1;
        case (addr_c)
            CSR_MSTATUS: cur_c = mstatus_c;
            CSR_MIE:     cur_c = XLEN'(mie_en_q) << IRQ_BASE;
            CSR_MTVEC:   cur_c = mtvec_q;
            CSR_MEPC:    cur_c = mepc_rd_c;
            CSR_MCAUSE:  cur_c = mcause_q;
            CSR_MIP:     cur_c = XLEN'(mip_c) << IRQ_BASE;
            CSR_MCYCLE:  cur_c = mcycle_q[31:0];
            CSR_MCYCLEH: cur_c = mcycle_q[63:32];
            default:     hit_c = 1'b0;
        endcase
    end

    assign bus.csr_rdata = (bus.csr_rd_en && hit_c) ? cur_c : '0;

    assign wr_c     = bus.csr_wr_en && (type_csr_op'(bus.csr_op) != OP_NONE);
    assign new_c    = csr_alu(type_csr_op'(bus.csr_op), cur_c, bus.csr_wdata);
    assign mip_wr_c = wr_c && (addr_c == CSR_MIP);

    // mret is only honoured in IDLE and pre-empts a same-cycle interrupt.
    assign mret_c = (state_q == ST_IDLE) && bus.csr_is_mret;
    assign take_c = (state_q == ST_IDLE) && mst_mie_q && irq_valid_c && !bus.csr_is_mret;

    assign cause_c = (XLEN-1)'(IRQ_BASE) + (XLEN-1)'(irq_idx_c);
    assign vec_c   = {mtvec_q[XLEN-1:2], 2'b00}
                   + ((mtvec_q[1:0] == 2'b01) ? (XLEN'(cause_c) << 2) : '0);

    // Next state: software writes first, trap/mret overrides on top.
    always_comb begin
        state_d       = state_q;
        redir_d       = redir_q;
        redir_d.taken = 1'b0;
        mst_mie_d     = mst_mie_q;
        mst_mpie_d    = mst_mpie_q;
        mie_en_d      = mie_en_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mcycle_d      = mcycle_q + 64'd1;

        if (wr_c) begin
            case (addr_c)
                CSR_MSTATUS: begin
                    mst_mie_d  = new_c[MSTATUS_MIE];
                    mst_mpie_d = new_c[MSTATUS_MPIE];
                end
                CSR_MIE:     mie_en_d = new_c[IRQ_BASE +: NUM_IRQ];
                CSR_MTVEC:   mtvec_d  = new_c;
                CSR_MEPC:    mepc_d   = new_c;
                CSR_MCAUSE:  mcause_d = new_c;
                CSR_MCYCLE:  mcycle_d = {mcycle_q[63:32], new_c};
                CSR_MCYCLEH: mcycle_d = {new_c, mcycle_q[31:0]};
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (mret_c) begin
                    state_d       = ST_TRAP;
                    redir_d.taken = 1'b1;
                    redir_d.evec  = mepc_rd_c;
                    mst_mie_d     = mst_mpie_q;
                    mst_mpie_d    = 1'b1;
                end else if (take_c) begin
                    state_d       = ST_TRAP;
                    redir_d.taken = 1'b1;
                    redir_d.evec  = vec_c;
                    mepc_d        = bus.csr_pc;
                    mcause_d      = {1'b1, cause_c};
                    mst_mpie_d    = mst_mie_q;
                    mst_mie_d     = 1'b0;
                end
            end
            ST_TRAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            redir_q    <= '0;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_en_q   <= '0;
            mtvec_q    <= RESET_MTVEC;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
        end else begin
            state_q    <= state_d;
            redir_q    <= redir_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_en_q   <= mie_en_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

    assign bus.epc_taken = redir_q.taken;
    assign bus.csr_evec  = redir_q.evec;

endmodule

// File: doc/csr_irq_unit.md
# csr_irq_unit

Machine-mode CSR file and trap controller for the 3-stage core. It replaces the single-timer-interrupt CSR block with NUM_IRQ prioritised, edge-latched interrupt lines and full csrrw/csrrs/csrrc semantics. It also adds MIE/MPIE stacking in mstatus, a 64-bit mcycle counter, and a registered trap/return redirect to the fetch stage. It sits beside the decode/execute stage and drives the PC mux via epc_taken/evec.

## Interface
- NUM_IRQ, 4, number of local interrupt lines (1..16), mapped to mip/mie bits 16+i
- RESET_MTVEC, 32'h0, reset value of mtvec
- clk  in  1  core clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- irq  in  NUM_IRQ  interrupt request lines, synchronous to clk, rising-edge sensitive
- csr_rd_en  in  1  CSR read strobe
- csr_wr_en  in  1  CSR write strobe
- csr_op  in  2  01 write, 10 set, 11 clear; 00 no-op
- csr_addr  in  12  CSR address
- csr_wdata  in  32  write operand (rs1 or zimm)
- csr_pc  in  32  PC of the instruction in EX
- csr_is_mret  in  1  mret in EX, one-cycle pulse
- csr_rdata  out  32  combinational read data; 0 when csr_rd_en=0 or address unmapped
- epc_taken  out  1  registered one-cycle redirect pulse
- csr_evec  out  32  registered redirect target, valid while epc_taken=1

## Operation
- CSRs: mstatus 0x300 (bit 3 MIE, bit 7 MPIE; other bits read 0), mie 0x304, mtvec 0x305, mepc 0x341 (bits 1:0 read 0), mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80.
- mie and mip implement only bits 16..16+NUM_IRQ-1. Other bits read 0 and ignore writes.
- Write value: op 01 → wdata; op 10 → old|wdata; op 11 → old&~wdata.
- Pending: a rising edge of irq[i] (irq[i]=1 and last-cycle irq[i]=0) sets mip[16+i].
  - Cleared by a CSR write, or automatically on trap entry for the selected source.
  - If an edge and a CSR clear hit the same bit in the same cycle, the edge wins.
- Eligible = mip & mie, plus MIE=1 and FSM in IDLE. Priority: lowest index wins.
- FSM IDLE → TRAP when eligible≠0. In the TRAP cycle:
  - epc_taken=1.
  - mepc ← csr_pc from the accept cycle.
  - mcause ← {1'b1, 31'(16+i)}.
  - MPIE ← MIE, MIE ← 0.
  - mip bit for source i cleared.
  - TRAP → IDLE after one cycle.
- Vector target:
  - mtvec[1:0]=00 → {mtvec[31:2],2'b00}.
  - mtvec[1:0]=01 → {mtvec[31:2],2'b00} + 4×(16+i).
  - Modes 10 and 11 behave as 00.
- mret in IDLE: epc_taken=1 next cycle, csr_evec=mepc, MIE ← MPIE, MPIE ← 1.
- mret and an eligible interrupt in the same cycle: mret wins. The interrupt is re-evaluated after the return using the restored MIE.
- Same-cycle CSR write and trap entry: the trap updates to mstatus, mepc and mcause win. The write applies to every other CSR.
- mcycle: 64-bit, increments every cycle. A software write to either half replaces that half, and the next increment happens the following cycle.
- Reset (rst_n=0 at posedge):
  - All CSRs 0; mtvec = RESET_MTVEC.
  - epc_taken=0, csr_evec=0.
  - FSM → IDLE, irq edge history = 0.
  - Reset mid-trap aborts the redirect.

## Timing
- irq[i] rises before edge N → mip set at N → epc_taken=1 during cycle after N+1 (2-cycle interrupt latency with mie and MIE already set).
- CSR write visible on csr_rdata the cycle after the write edge. Same-cycle read returns the old value.
- epc_taken never asserts on consecutive cycles. At least one IDLE cycle separates redirects.
- mret with csr_is_mret at edge M → epc_taken high during cycle M+1.

## Structure
- csr_pkg: CSR address enum (type_csr_addr), op encodings, mstatus bit positions, FSM state enum {IDLE, TRAP}.
- Sub-module csr_irq_arb: edge detect, pending-set vector, fixed-priority encoder. Outputs valid flag and index.
- Top: CSR registers, read mux, write-op ALU, trap FSM, mcycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → all reads 0, mtvec=RESET_MTVEC, epc_taken=0, csr_evec=0.
- Direct trap:
  - Setup: mtvec=0x100, mie=0x10000, mstatus=0x8, csr_pc=0x40. Pulse irq[0].
  - Expected: epc_taken pulse, csr_evec=0x100, mepc=0x40, mcause=0x80000010, mstatus=0x80, mip[16]=0.
- Vectored trap with priority:
  - Setup: mtvec=0x201, mie=0xF0000. Raise irq[2] and irq[1] in the same cycle.
  - Expected: csr_evec=0x200+4×17=0x244, mcause=0x80000011, mip[18] still 1.
- Return and re-entry: after the previous case, pulse mret → csr_evec=mepc, MIE=1. Then irq 2 traps 2 cycles later with mcause=0x80000012.
- Set/clear ops: csrrs mie 0x30000 then csrrc 0x10000 → mie=0x20000. Writes to mie bit 3 read back 0.
- Collisions:
  - mret and eligible irq in the same cycle → only the mret redirect occurs first.
  - irq edge concurrent with a mip clear → bit stays 1.
  - rst_n low during the TRAP cycle → epc_taken=0 the next cycle.
